// File: rtl/display_scheduler_pkg.sv
// rtl/display_scheduler_pkg.sv - screen-sequencer types, layer bit indices and default frame counts
package display_scheduler_pkg;

  typedef enum logic [1:0] {
    S_START   = 2'd0,
    S_PLAY    = 2'd1,
    S_RESULT  = 2'd2,
    S_RESTART = 2'd3
  } sched_state_t;

  localparam int LAYER_START_TXT   = 0;
  localparam int LAYER_DUCK        = 1;
  localparam int LAYER_SCORE_PLAY  = 2;
  localparam int LAYER_SCORE_END   = 3;
  localparam int LAYER_RESULT      = 4;
  localparam int LAYER_RESTART_TXT = 5;

  localparam int BLINK_FRAMES_DEF  = 30;
  localparam int RESULT_FRAMES_DEF = 120;
  localparam int ROUND_FRAMES_DEF  = 3600;

  // 1024x768@60: first blanking line, first pixel of that line
  localparam logic [10:0] VL_BLANK_START = 11'd768;
  localparam logic [10:0] HCOUNT_START   = 11'd0;

  function automatic logic [5:0] layers_for(input sched_state_t s, input logic blink);
    logic [5:0] l;
    l = '0;
    case (s)
      S_START: l[LAYER_START_TXT] = blink;
      S_PLAY: begin
        l[LAYER_DUCK]       = 1'b1;
        l[LAYER_SCORE_PLAY] = 1'b1;
      end
      S_RESULT: begin
        l[LAYER_SCORE_END] = 1'b1;
        l[LAYER_RESULT]    = 1'b1;
      end
      default: begin
        l[LAYER_SCORE_END]   = 1'b1;
        l[LAYER_RESULT]      = 1'b1;
        l[LAYER_RESTART_TXT] = blink;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/display_scheduler_frame_tick_gen.sv
// rtl/display_scheduler_frame_tick_gen.sv - registered one-cycle pulse at a fixed (vcount,hcount) point
module frame_tick_gen
  import display_scheduler_pkg::*;
#(
  parameter logic [10:0] V_MATCH = VL_BLANK_START,
  parameter logic [10:0] H_MATCH = HCOUNT_START
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vcount,
  input  logic [10:0] hcount,
  output logic        frame_tick
);

  logic tick_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_q <= 1'b0;
    else        tick_q <= (vcount == V_MATCH) && (hcount == H_MATCH);
  end

  assign frame_tick = tick_q;

endmodule

// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - game screen sequencer; layer enables change only at vblank entry
// Optional round timer: define ROUND_TIMER_EN to end PLAY after ROUND_FRAMES frames.
module display_scheduler
  import display_scheduler_pkg::*;
#(
  parameter int BLINK_FRAMES  = BLINK_FRAMES_DEF,
  parameter int RESULT_FRAMES = RESULT_FRAMES_DEF,
  parameter int ROUND_FRAMES  = ROUND_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] vcount,
  input  logic [10:0] hcount,
  input  logic        start_req,
  input  logic        round_over,
  input  logic        restart_req,
  output logic        frame_tick,
  output logic [1:0]  state,
  output logic [5:0]  layer_en,
  output logic        clear_scores,
  output logic [11:0] frames_left
);

  localparam int FRAME_MAX = (RESULT_FRAMES > ROUND_FRAMES) ? RESULT_FRAMES : ROUND_FRAMES;
  localparam int FCW       = $clog2(FRAME_MAX + 1);
  localparam int BCW       = $clog2(BLINK_FRAMES + 1);
  localparam logic [FCW-1:0] FRAME_SAT   = FCW'(FRAME_MAX);
  localparam logic [FCW-1:0] RESULT_LAST = FCW'(RESULT_FRAMES - 1);
  localparam logic [BCW-1:0] BLINK_LAST  = BCW'(BLINK_FRAMES - 1);

  sched_state_t   state_q, state_d;
  logic           pend_start_q, pend_start_d;
  logic           pend_over_q, pend_over_d;
  logic           pend_restart_q, pend_restart_d;
  logic [FCW-1:0] frame_cnt_q, frame_cnt_d;
  logic [BCW-1:0] blink_cnt_q, blink_cnt_d;
  logic           blink_q, blink_d;
  logic [5:0]     layer_q, layer_d;
  logic           clear_q, clear_d;
  logic           start_v, over_v, restart_v, timer_expire, changed;

  frame_tick_gen u_tick (
    .clk        (clk),
    .rst_n      (rst_n),
    .vcount     (vcount),
    .hcount     (hcount),
    .frame_tick (frame_tick)
  );

`ifdef ROUND_TIMER_EN
  logic [11:0] frames_left_q, frames_left_d;
  assign timer_expire = (frames_left_q == 12'd1);
`else
  assign timer_expire = 1'b0;
`endif

  // A request arriving in the tick cycle itself is counted for that tick
  assign start_v   = pend_start_q | start_req;
  assign over_v    = pend_over_q | round_over;
  assign restart_v = pend_restart_q | restart_req;

  always_comb begin
    state_d        = state_q;
    pend_start_d   = start_v;
    pend_over_d    = over_v;
    pend_restart_d = restart_v;
    frame_cnt_d    = frame_cnt_q;
    blink_cnt_d    = blink_cnt_q;
    blink_d        = blink_q;
    layer_d        = layer_q;
    clear_d        = 1'b0;
    changed        = 1'b0;
`ifdef ROUND_TIMER_EN
    frames_left_d  = frames_left_q;
`endif
    if (frame_tick) begin
      case (state_q)
        S_START:   if (start_v) state_d = S_PLAY;
        S_PLAY:    if (over_v || timer_expire) state_d = S_RESULT;
        S_RESULT:  if (frame_cnt_q == RESULT_LAST) state_d = S_RESTART;
        S_RESTART: if (restart_v) state_d = S_PLAY;
        default:   state_d = S_START;
      endcase
      changed        = (state_d != state_q);
      pend_start_d   = 1'b0;
      pend_over_d    = 1'b0;
      pend_restart_d = 1'b0;

      if (changed)                  frame_cnt_d = '0;
      else if (frame_cnt_q != FRAME_SAT) frame_cnt_d = frame_cnt_q + FCW'(1);

      if (changed && (state_d == S_START || state_d == S_RESTART)) begin
        blink_d     = 1'b1;
        blink_cnt_d = '0;
      end else if (blink_cnt_q == BLINK_LAST) begin
        blink_d     = ~blink_q;
        blink_cnt_d = '0;
      end else begin
        blink_cnt_d = blink_cnt_q + BCW'(1);
      end

`ifdef ROUND_TIMER_EN
      if (state_d != S_PLAY)      frames_left_d = 12'd0;
      else if (state_q != S_PLAY) frames_left_d = 12'(ROUND_FRAMES);
      else                        frames_left_d = frames_left_q - 12'd1;
`endif

      layer_d = layers_for(state_d, blink_d);
      clear_d = changed && (state_d == S_PLAY);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_START;
      pend_start_q   <= 1'b0;
      pend_over_q    <= 1'b0;
      pend_restart_q <= 1'b0;
      frame_cnt_q    <= '0;
      blink_cnt_q    <= '0;
      blink_q        <= 1'b1;
      layer_q        <= 6'b000001;
      clear_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      pend_start_q   <= pend_start_d;
      pend_over_q    <= pend_over_d;
      pend_restart_q <= pend_restart_d;
      frame_cnt_q    <= frame_cnt_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_q        <= blink_d;
      layer_q        <= layer_d;
      clear_q        <= clear_d;
    end
  end

`ifdef ROUND_TIMER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frames_left_q <= 12'd0;
    else        frames_left_q <= frames_left_d;
  end
  assign frames_left = frames_left_q;
`else
  assign frames_left = 12'd0;
`endif

  assign state        = state_q;
  assign layer_en     = layer_q;
  assign clear_scores = clear_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - directed and random checks of display_scheduler against a frame-level model
module tb_display_scheduler;

  localparam int BLINK = 2;
  localparam int RES   = 3;
  localparam int ROUND = 5;
`ifdef ROUND_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] vcount = '0;
  logic [10:0] hcount = '0;
  logic        start_req = 1'b0;
  logic        round_over = 1'b0;
  logic        restart_req = 1'b0;
  logic        frame_tick;
  logic [1:0]  state;
  logic [5:0]  layer_en;
  logic        clear_scores;
  logic [11:0] frames_left;

  int errors = 0;
  int checks = 0;
  int c = 0;
  int tick_seen = 0;
  int m_state = 0;
  int m_ticks = 0;
  int m_blink = 0;
  bit m_ps = 0, m_po = 0, m_pr = 0;
  bit exp_tick = 0, exp_clear = 0;
  bit pat [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  display_scheduler #(
    .BLINK_FRAMES  (BLINK),
    .RESULT_FRAMES (RES),
    .ROUND_FRAMES  (ROUND)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vcount       (vcount),
    .hcount       (hcount),
    .start_req    (start_req),
    .round_over   (round_over),
    .restart_req  (restart_req),
    .frame_tick   (frame_tick),
    .state        (state),
    .layer_en     (layer_en),
    .clear_scores (clear_scores),
    .frames_left  (frames_left)
  );

  always #5 clk = ~clk;

  // Compressed frame of 32 cycles: 4 lines of 8 pixels, line 3 is the first blanking line
  function automatic logic [10:0] vrow(input int row);
    case (row)
      0: return 11'd0;
      1: return 11'd100;
      2: return 11'd200;
      default: return 11'd768;
    endcase
  endfunction

  function automatic logic [5:0] m_layers();
    bit blink;
    blink = ((m_blink / BLINK) % 2) == 0;
    case (m_state)
      0: return blink ? 6'h01 : 6'h00;
      1: return 6'h06;
      2: return 6'h18;
      default: return blink ? 6'h38 : 6'h18;
    endcase
  endfunction

  function automatic int m_frames_left();
    return (TIMER && m_state == 1) ? ROUND - m_ticks : 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_tick(input bit s, input bit o, input bit r);
    int nxt;
    nxt = m_state;
    case (m_state)
      0: if (m_ps | s) nxt = 1;
      1: if ((m_po | o) || (TIMER && m_ticks + 1 == ROUND)) nxt = 2;
      2: if (m_ticks + 1 == RES) nxt = 3;
      default: if (m_pr | r) nxt = 1;
    endcase
    if (nxt != m_state) begin
      m_ticks = 0;
      m_blink = (nxt == 0 || nxt == 3) ? 0 : m_blink + 1;
    end else begin
      m_ticks++;
      m_blink++;
    end
    exp_clear = (nxt == 1) && (m_state != 1);
    m_state = nxt;
    m_ps = 0; m_po = 0; m_pr = 0;
  endtask

  task automatic run_cycle(input bit s, input bit o, input bit r, input bit rn);
    @(negedge clk);
    chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
    chk("state", 32'(state), 32'(m_state));
    chk("layer_en", 32'(layer_en), 32'(m_layers()));
    chk("clear_scores", 32'(clear_scores), 32'(exp_clear));
    chk("frames_left", 32'(frames_left), 32'(m_frames_left()));
    if (frame_tick === 1'b1) tick_seen++;
    rst_n       = rn;
    hcount      = 11'(c % 8);
    vcount      = vrow(c / 8);
    start_req   = s;
    round_over  = o;
    restart_req = r;
    if (!rn) begin
      m_state = 0; m_ticks = 0; m_blink = 0;
      m_ps = 0; m_po = 0; m_pr = 0;
      exp_tick = 0; exp_clear = 0;
    end else begin
      if (exp_tick) model_tick(s, o, r);
      else begin
        exp_clear = 0;
        m_ps |= s; m_po |= o; m_pr |= r;
      end
      exp_tick = (c == 24);
    end
    c = (c + 1) % 32;
  endtask

  task automatic run_to(input int target);
    while (c != target) run_cycle(0, 0, 0, 1);
  endtask

  task automatic run_n(input int n);
    repeat (n) run_cycle(0, 0, 0, 1);
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_mid_frame();
    run_to(10);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 0);
    run_cycle(0, 0, 0, 1);
  endtask

  initial begin
    // reset at power-up, then again in the middle of a frame
    repeat (3) run_cycle(0, 0, 0, 0);
    run_n(7);
    reset_mid_frame();
    peek();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_layer", 32'(layer_en), 32'h01);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    chk("rst_clear", 32'(clear_scores), 32'd0);
    chk("rst_frames_left", 32'(frames_left), 32'd0);
    tick_seen = 0;
    run_n(128);
    chk("tick_per_frame", 32'(tick_seen), 32'd4);

    // blink of start text, restart requests ignored
    reset_mid_frame();
    for (int f = 0; f < 8; f++) begin
      run_to(20);
      peek();
      chk("blink_start_txt", 32'(layer_en[0]), 32'(pat[f]));
      chk("start_ignores_restart", 32'(state), 32'd0);
      run_to(5);
      run_cycle(0, 0, 1, 1);
    end

    // start mid-frame takes effect only at the next tick
    run_to(9);
    run_cycle(1, 0, 0, 1);
    run_to(20);
    peek();
    chk("start_wait_state", 32'(state), 32'd0);
    run_to(25);
    peek();
    chk("start_tick_high", 32'(frame_tick), 32'd1);
    chk("start_tick_state", 32'(state), 32'd0);
    run_to(26);
    peek();
    chk("play_state", 32'(state), 32'd1);
    chk("play_layer", 32'(layer_en), 32'h06);
    chk("play_clear", 32'(clear_scores), 32'd1);
    run_to(27);
    peek();
    chk("play_clear_once", 32'(clear_scores), 32'd0);

    // round_over and restart in one frame, then result hold
    run_to(5);
    run_cycle(0, 1, 1, 1);
    run_to(26);
    peek();
    chk("result_state", 32'(state), 32'd2);
    chk("result_layer", 32'(layer_en), 32'h18);
    for (int i = 0; i < 3; i++) begin
      run_n(32);
      peek();
      chk("hold_state", 32'(state), (i < 2) ? 32'd2 : 32'd3);
      chk("hold_layer", 32'(layer_en), (i < 2) ? 32'h18 : 32'h38);
    end
    run_to(3);
    run_cycle(0, 1, 1, 1);
    run_to(26);
    peek();
    chk("restart_play_state", 32'(state), 32'd1);
    chk("restart_play_clear", 32'(clear_scores), 32'd1);

    // start on the tick cycle vs one cycle later
    reset_mid_frame();
    run_to(25);
    run_cycle(1, 0, 0, 1);
    peek();
    chk("start_on_tick", 32'(state), 32'd1);
    reset_mid_frame();
    run_to(26);
    run_cycle(1, 0, 0, 1);
    run_to(25);
    peek();
    chk("start_late_wait", 32'(state), 32'd0);
    run_to(26);
    peek();
    chk("start_late_play", 32'(state), 32'd1);
    chk("start_late_layer", 32'(layer_en), 32'h06);

    // round timer
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        run_n(32);
        peek();
      end
`ifdef ROUND_TIMER_EN
      chk("timer_state", 32'(state), (i < 5) ? 32'd1 : 32'd2);
      chk("timer_left", 32'(frames_left), (i < 5) ? 32'(5 - i) : 32'd0);
`else
      chk("no_timer_state", 32'(state), 32'd1);
      chk("no_timer_left", 32'(frames_left), 32'd0);
`endif
    end

    // random requests against the model
    reset_mid_frame();
    repeat (80 * 32) begin
      int k;
      k = $urandom_range(0, 11);
      run_cycle(k == 0, k == 1 || k == 3, k == 2 || k == 3, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
